// File: rtl/demux_1to2.sv
// Registered 1-to-2 demultiplexer with per-channel valid strobes and transfer counters.
// One clock of latency; the unselected channel always reads zero.
module demux_1to2 #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     data,
    input  logic                 select,
    input  logic                 in_valid,
    output logic [WIDTH-1:0]     result0,
    output logic [WIDTH-1:0]     result1,
    output logic                 valid0,
    output logic                 valid1,
    output logic [CNT_WIDTH-1:0] count0,
    output logic [CNT_WIDTH-1:0] count1
);

    logic [WIDTH-1:0]     result0_d, result0_q;
    logic [WIDTH-1:0]     result1_d, result1_q;
    logic                 valid0_d, valid0_q;
    logic                 valid1_d, valid1_q;
    logic [CNT_WIDTH-1:0] count0_d, count0_q;
    logic [CNT_WIDTH-1:0] count1_d, count1_q;

    // Data and strobes are rebuilt every cycle; only the counters carry state.
    always_comb begin
        result0_d = '0;
        result1_d = '0;
        valid0_d  = 1'b0;
        valid1_d  = 1'b0;
        count0_d  = count0_q;
        count1_d  = count1_q;
        if (in_valid) begin
            if (select) begin
                result1_d = data;
                valid1_d  = 1'b1;
                count1_d  = count1_q + CNT_WIDTH'(1);
            end else begin
                result0_d = data;
                valid0_d  = 1'b1;
                count0_d  = count0_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result0_q <= '0;
            result1_q <= '0;
            valid0_q  <= 1'b0;
            valid1_q  <= 1'b0;
            count0_q  <= '0;
            count1_q  <= '0;
        end else begin
            result0_q <= result0_d;
            result1_q <= result1_d;
            valid0_q  <= valid0_d;
            valid1_q  <= valid1_d;
            count0_q  <= count0_d;
            count1_q  <= count1_d;
        end
    end

    assign result0 = result0_q;
    assign result1 = result1_q;
    assign valid0  = valid0_q;
    assign valid1  = valid1_q;
    assign count0  = count0_q;
    assign count1  = count1_q;

endmodule

// File: tb/tb_demux_1to2.sv
// Scoreboard bench for demux_1to2: a default instance plus a 4-bit-counter instance
// sharing the same stimulus, so counter wrap is observed alongside normal routing.
module tb_demux_1to2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  data;
    logic        select;
    logic        in_valid;

    logic [7:0]  result0, result1;
    logic        valid0, valid1;
    logic [15:0] count0, count1;

    logic [7:0]  w_result0, w_result1;
    logic        w_valid0, w_valid1;
    logic [3:0]  w_count0, w_count1;

    always #5 clk = ~clk;

    demux_1to2 #(.WIDTH(8), .CNT_WIDTH(16)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data     (data),
        .select   (select),
        .in_valid (in_valid),
        .result0  (result0),
        .result1  (result1),
        .valid0   (valid0),
        .valid1   (valid1),
        .count0   (count0),
        .count1   (count1)
    );

    demux_1to2 #(.WIDTH(8), .CNT_WIDTH(4)) u_dut_wrap (
        .clk      (clk),
        .rst_n    (rst_n),
        .data     (data),
        .select   (select),
        .in_valid (in_valid),
        .result0  (w_result0),
        .result1  (w_result1),
        .valid0   (w_valid0),
        .valid1   (w_valid1),
        .count0   (w_count0),
        .count1   (w_count1)
    );

    typedef struct packed {
        logic [7:0]  r0;
        logic [7:0]  r1;
        logic        v0;
        logic        v1;
        logic [15:0] c0;
        logic [15:0] c1;
        logic [3:0]  w0;
        logic [3:0]  w1;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Reference counters, kept independently of the DUT.
    logic [15:0] m_c0 = '0, m_c1 = '0;
    logic [3:0]  m_w0 = '0, m_w1 = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one input cycle, push its expected outcome, then pop and compare after the edge.
    task automatic step(input logic rn, input logic iv, input logic sel, input logic [7:0] d);
        exp_t e;
        exp_t o;
        rst_n    = rn;
        in_valid = iv;
        select   = sel;
        data     = d;
        e = '0;
        if (!rn) begin
            m_c0 = '0; m_c1 = '0; m_w0 = '0; m_w1 = '0;
        end else if (iv) begin
            if (sel) begin
                e.r1 = d; e.v1 = 1'b1;
                m_c1 = m_c1 + 16'd1; m_w1 = m_w1 + 4'd1;
            end else begin
                e.r0 = d; e.v0 = 1'b1;
                m_c0 = m_c0 + 16'd1; m_w0 = m_w0 + 4'd1;
            end
        end
        e.c0 = m_c0; e.c1 = m_c1; e.w0 = m_w0; e.w1 = m_w1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check_eq("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            o = sb.pop_front();
            check_eq("result0", {24'd0, result0}, {24'd0, o.r0});
            check_eq("result1", {24'd0, result1}, {24'd0, o.r1});
            check_eq("valid0", {31'd0, valid0}, {31'd0, o.v0});
            check_eq("valid1", {31'd0, valid1}, {31'd0, o.v1});
            check_eq("count0", {16'd0, count0}, {16'd0, o.c0});
            check_eq("count1", {16'd0, count1}, {16'd0, o.c1});
            check_eq("wrap_count0", {28'd0, w_count0}, {28'd0, o.w0});
            check_eq("wrap_count1", {28'd0, w_count1}, {28'd0, o.w1});
            check_eq("wrap_result0", {24'd0, w_result0}, {24'd0, o.r0});
            check_eq("onehot_valid", {31'd0, valid0 & valid1}, 32'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; select = 1'b0; data = '0;
        @(posedge clk);
        #1;

        // Reset held with a live word on the inputs.
        step(1'b0, 1'b1, 1'b0, 8'hFF);
        step(1'b0, 1'b1, 1'b0, 8'hFF);
        check_eq("reset_count0", {16'd0, count0}, 32'd0);

        // Exhaustive routing on both channels.
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 1'b1, 1'b0, 8'(i));
            step(1'b1, 1'b1, 1'b1, 8'(i));
        end
        check_eq("final_count0", {16'd0, count0}, 32'd256);
        check_eq("final_count1", {16'd0, count1}, 32'd256);

        // Idle cycles clear the data path and hold the counters.
        step(1'b1, 1'b0, 1'b1, 8'hA5);
        step(1'b1, 1'b0, 1'b0, 8'hA5);
        check_eq("idle_count1", {16'd0, count1}, 32'd256);

        // Back-to-back alternating channels.
        step(1'b1, 1'b1, 1'b0, 8'h3C);
        check_eq("b2b_first", {24'd0, result0}, 32'h3C);
        step(1'b1, 1'b1, 1'b1, 8'hC3);
        check_eq("b2b_second", {24'd0, result1}, 32'hC3);
        step(1'b1, 1'b0, 1'b0, 8'h00);

        // Counter wrap on the 4-bit instance after a fresh reset.
        step(1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 1; i <= 17; i++) begin
            step(1'b1, 1'b1, 1'b0, 8'(i));
            if (i == 15) check_eq("wrap_at_15", {28'd0, w_count0}, 32'd15);
            if (i == 16) check_eq("wrap_at_16", {28'd0, w_count0}, 32'd0);
            if (i == 17) check_eq("wrap_at_17", {28'd0, w_count0}, 32'd1);
        end
        check_eq("wrap_count1_zero", {28'd0, w_count1}, 32'd0);

        // Reset mid-stream drops the word on that edge, then operation resumes.
        step(1'b1, 1'b1, 1'b1, 8'h5A);
        step(1'b0, 1'b1, 1'b1, 8'h77);
        check_eq("midrst_result1", {24'd0, result1}, 32'd0);
        check_eq("midrst_count1", {16'd0, count1}, 32'd0);
        step(1'b1, 1'b1, 1'b1, 8'h81);
        check_eq("resume_count1", {16'd0, count1}, 32'd1);
        step(1'b1, 1'b0, 1'b0, 8'h00);

        if (sb.size() != 0) check_eq("scoreboard_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
